// File: rtl/sgmii_mdio_sched.sv
// Round-robin Clause 22 MDIO master shared by the four SGMII PHY management ports.
// MDC is derived from the system clock; MDIO changes on MDC falling edges and is sampled on rising edges.
module sgmii_mdio_sched #(
  parameter int MDC_DIV = 25
) (
  input  logic        bd_fclk0_125m,
  input  logic        bd_aresetn,
  input  logic [3:0]  req_valid,
  input  logic [3:0]  req_write,
  input  logic [19:0] req_phyad,
  input  logic [19:0] req_regad,
  input  logic [63:0] req_wdata,
  output logic [3:0]  req_ready,
  output logic [3:0]  rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdio_mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam int CW = $clog2(MDC_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(MDC_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_EDGE, S_SHIFT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          wr_q, wr_d;
  logic [63:0]   frame_q, frame_d;
  logic [5:0]    bit_q, bit_d;
  logic          mdio_o_q, mdio_o_d;
  logic          mdio_t_q, mdio_t_d;
  logic          err_w_q, err_w_d;
  logic [15:0]   data_w_q, data_w_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [3:0]    ready_q, ready_d;

  logic          wrap, fall_tick, rise_tick;
  logic          grant_any;
  logic [1:0]    grant_idx;
  logic [1:0]    pick;
  logic          g_wr;
  logic [4:0]    g_phyad, g_regad;
  logic [15:0]   g_wdata;

  assign wrap      = (cnt_q == CNT_LAST);
  assign fall_tick = wrap & mdc_q;
  assign rise_tick = wrap & ~mdc_q;

  // Search upward from the port after the last one served so no requester can starve another.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    pick      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      pick = last_q + 2'(k);
      if (!grant_any && req_valid[pick]) begin
        grant_any = 1'b1;
        grant_idx = pick;
      end
    end
  end

  assign g_wr    = req_write[grant_idx];
  assign g_phyad = req_phyad[grant_idx*5 +: 5];
  assign g_regad = req_regad[grant_idx*5 +: 5];
  assign g_wdata = req_wdata[grant_idx*16 +: 16];

  always_comb begin
    state_d  = state_q;
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    mdc_d    = wrap ? ~mdc_q : mdc_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    frame_d  = frame_q;
    bit_d    = bit_q;
    mdio_o_d = mdio_o_q;
    mdio_t_d = mdio_t_q;
    err_w_d  = err_w_q;
    data_w_d = data_w_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ready_d  = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          ready_d[grant_idx] = 1'b1;
          gnt_d    = grant_idx;
          wr_d     = g_wr;
          // Read frames carry ones after REGAD so a released line stays at the pull-up level.
          frame_d  = {32'hFFFF_FFFF, 2'b01, (g_wr ? 2'b01 : 2'b10), g_phyad, g_regad,
                      (g_wr ? 2'b10 : 2'b11), (g_wr ? g_wdata : 16'hFFFF)};
          err_w_d  = 1'b0;
          data_w_d = 16'h0000;
          state_d  = S_WAIT_EDGE;
        end
      end
      S_WAIT_EDGE: begin
        if (fall_tick) begin
          mdio_t_d = 1'b0;
          mdio_o_d = frame_q[63];
          frame_d  = {frame_q[62:0], 1'b1};
          bit_d    = 6'd0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (fall_tick) begin
          if (bit_q == 6'd63) begin
            mdio_t_d = 1'b1;
            mdio_o_d = 1'b1;
            rdata_d  = wr_q ? 16'h0000 : data_w_q;
            err_d    = wr_q ? 1'b0 : err_w_q;
            state_d  = S_DONE;
          end else begin
            bit_d    = bit_q + 6'd1;
            mdio_o_d = frame_q[63];
            frame_d  = {frame_q[62:0], 1'b1};
            mdio_t_d = ~wr_q & (bit_q >= 6'd45);
          end
        end else if (rise_tick && !wr_q) begin
          if (bit_q == 6'd47) begin
            err_w_d = mdio_i;
          end else if (bit_q >= 6'd48) begin
            data_w_d = {data_w_q[14:0], mdio_i};
          end
        end
      end
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge bd_fclk0_125m or negedge bd_aresetn) begin
    if (!bd_aresetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mdc_q    <= 1'b0;
      last_q   <= 2'd3;
      gnt_q    <= 2'd0;
      wr_q     <= 1'b0;
      frame_q  <= '1;
      bit_q    <= 6'd0;
      mdio_o_q <= 1'b1;
      mdio_t_q <= 1'b1;
      err_w_q  <= 1'b0;
      data_w_q <= 16'h0000;
      rdata_q  <= 16'h0000;
      err_q    <= 1'b0;
      ready_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mdc_q    <= mdc_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      frame_q  <= frame_d;
      bit_q    <= bit_d;
      mdio_o_q <= mdio_o_d;
      mdio_t_q <= mdio_t_d;
      err_w_q  <= err_w_d;
      data_w_q <= data_w_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state_q == S_DONE) ? (4'b0001 << gnt_q) : 4'b0000;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);
  assign mdio_mdc  = mdc_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_t    = mdio_t_q;

endmodule

// File: tb/tb_sgmii_mdio_sched.sv
// Bench for sgmii_mdio_sched: pin-level frame decoder, PHY model, and response scoreboard.
module tb_sgmii_mdio_sched;

  localparam int DIV = 25;

  logic        clk = 1'b0;
  logic        bd_aresetn = 1'b0;
  logic [3:0]  req_valid = '0, req_write = '0;
  logic [19:0] req_phyad = '0, req_regad = '0;
  logic [63:0] req_wdata = '0;
  logic [3:0]  req_ready, rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err, busy, mdio_mdc, mdio_o, mdio_t;
  logic        mdio_i = 1'b1;

  logic [3:0]  req_valid_f = '0, req_write_f = '0;
  logic [19:0] req_phyad_f = '0, req_regad_f = '0;
  logic [63:0] req_wdata_f = '0;
  logic [3:0]  req_ready_f, rsp_valid_f;
  logic [15:0] rsp_rdata_f;
  logic        rsp_err_f, busy_f, mdio_mdc_f, mdio_o_f, mdio_t_f;
  logic        mdio_i_f = 1'b1;

  always #4 clk = ~clk;

  sgmii_mdio_sched #(.MDC_DIV(DIV)) u_dut (
    .bd_fclk0_125m(clk), .bd_aresetn(bd_aresetn),
    .req_valid(req_valid), .req_write(req_write), .req_phyad(req_phyad),
    .req_regad(req_regad), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mdio_mdc(mdio_mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i)
  );

  sgmii_mdio_sched #(.MDC_DIV(2)) u_fast (
    .bd_fclk0_125m(clk), .bd_aresetn(bd_aresetn),
    .req_valid(req_valid_f), .req_write(req_write_f), .req_phyad(req_phyad_f),
    .req_regad(req_regad_f), .req_wdata(req_wdata_f), .req_ready(req_ready_f),
    .rsp_valid(rsp_valid_f), .rsp_rdata(rsp_rdata_f), .rsp_err(rsp_err_f), .busy(busy_f),
    .mdio_mdc(mdio_mdc_f), .mdio_o(mdio_o_f), .mdio_t(mdio_t_f), .mdio_i(mdio_i_f)
  );

  typedef struct {
    logic [3:0]  port;
    logic [15:0] rdata;
    logic        err;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  rsp_t        exp_rsp[$];
  logic [63:0] exp_line[$];
  logic [63:0] exp_tm[$];
  int          grant_log[$];

  logic        phy_present = 1'b0;
  logic [15:0] phy_data = 16'h0000;

  // monitor state
  int          cyc = 0, start_cyc = 0, end_cyc = -1, idx = 0, frames_done = 0;
  logic        in_frame = 1'b0, mdc_prev = 1'b0, busy_ok = 1'b1;
  logic [63:0] line = '0, tm = '0, last_line = '0, l_exp, m_exp;
  logic [1:0]  model_last = 2'd3, pred;
  logic        m_wr;
  logic [4:0]  m_phy, m_reg;
  logic [15:0] m_wd;
  rsp_t        e, pe;

  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] v);
    logic [1:0] r = last;
    logic found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] p = last + 2'(k);
      if (!found && v[p]) begin found = 1'b1; r = p; end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!bd_aresetn) begin
      in_frame = 1'b0; mdc_prev = 1'b0; idx = 0; mdio_i = 1'b1; end_cyc = -1;
      model_last = 2'd3;
      exp_rsp.delete(); exp_line.delete(); exp_tm.delete();
    end else begin
      cyc++;
      // grant scoreboard: predict the winner and queue its expected frame and response
      if (req_ready != 4'b0000) begin
        pred = rr_pick(model_last, req_valid);
        checks++;
        if (req_ready !== (4'b0001 << pred)) begin
          errors++;
          $display("FAIL grant: req_ready=%b required %b", req_ready, 4'b0001 << pred);
        end
        model_last = pred;
        grant_log.push_back(int'(pred));
        m_wr  = req_write[pred];
        m_phy = req_phyad[pred*5 +: 5];
        m_reg = req_regad[pred*5 +: 5];
        m_wd  = req_wdata[pred*16 +: 16];
        exp_line.push_back({32'hFFFF_FFFF, 2'b01, (m_wr ? 2'b01 : 2'b10), m_phy, m_reg,
                            (m_wr ? 2'b10 : {1'b1, ~phy_present}),
                            (m_wr ? m_wd : (phy_present ? phy_data : 16'hFFFF))});
        exp_tm.push_back(m_wr ? 64'h0 : 64'h3_FFFF);
        pe.port  = 4'b0001 << pred;
        pe.rdata = m_wr ? 16'h0000 : (phy_present ? phy_data : 16'hFFFF);
        pe.err   = m_wr ? 1'b0 : ~phy_present;
        exp_rsp.push_back(pe);
      end
      if (rsp_valid != 4'b0000) begin
        checks++;
        if (exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b required none", rsp_valid);
        end else begin
          e = exp_rsp.pop_front();
          if ({rsp_valid, rsp_rdata, rsp_err, busy} !== {e.port, e.rdata, e.err, 1'b1}) begin
            errors++;
            $display("FAIL rsp: valid=%b rdata=%h err=%b busy=%b required valid=%b rdata=%h err=%b busy=1",
                     rsp_valid, rsp_rdata, rsp_err, busy, e.port, e.rdata, e.err);
          end
        end
      end
      // pin decoder and PHY model
      if (mdc_prev && !mdio_mdc) begin
        if (in_frame) begin
          if (idx == 63) begin
            in_frame = 1'b0;
            frames_done++;
            last_line = line;
            checks++;
            if (exp_line.size() == 0) begin
              errors++;
              $display("FAIL frame_unexpected: line=%h required none", line);
            end else begin
              l_exp = exp_line.pop_front();
              m_exp = exp_tm.pop_front();
              if (line !== l_exp || tm !== m_exp) begin
                errors++;
                $display("FAIL frame_bits: line=%h tmask=%h required line=%h tmask=%h", line, tm, l_exp, m_exp);
              end
            end
            checks++;
            if (cyc - start_cyc !== 128 * DIV) begin
              errors++;
              $display("FAIL frame_len: %0d clocks required %0d", cyc - start_cyc, 128 * DIV);
            end
            checks++;
            if (busy_ok !== 1'b1) begin
              errors++;
              $display("FAIL busy_in_frame: busy dropped=1 required 0");
            end
            end_cyc = cyc;
          end else begin
            idx++;
          end
        end else if (!mdio_t) begin
          in_frame = 1'b1; idx = 0; start_cyc = cyc; busy_ok = 1'b1; line = '0; tm = '0;
          if (end_cyc >= 0) begin
            checks++;
            if (cyc - end_cyc < 2 * DIV) begin
              errors++;
              $display("FAIL idle_gap: %0d clocks required >= %0d", cyc - end_cyc, 2 * DIV);
            end
          end
        end
        if (!phy_present || !in_frame || idx < 47) mdio_i = 1'b1;
        else if (idx == 47) mdio_i = 1'b0;
        else mdio_i = phy_data[63 - idx];
      end
      if (!mdc_prev && mdio_mdc && in_frame) begin
        line[63 - idx] = mdio_t ? mdio_i : mdio_o;
        tm[63 - idx]   = mdio_t;
      end
      if (in_frame && !busy) busy_ok = 1'b0;
      mdc_prev = mdio_mdc;
    end
  end

  task automatic set_port(input int p, input logic wr, input logic [4:0] phy,
                          input logic [4:0] rg, input logic [15:0] wd);
    req_write[p] = wr;
    req_phyad[p*5 +: 5] = phy;
    req_regad[p*5 +: 5] = rg;
    req_wdata[p*16 +: 16] = wd;
  endtask

  task automatic request(input logic [3:0] mask);
    int n = 0;
    req_valid = mask;
    while (req_valid != 4'b0000 && n < 20000) begin
      @(negedge clk); #1;
      req_valid = req_valid & ~req_ready;
      n++;
    end
    if (req_valid != 4'b0000) begin
      checks++; errors++;
      $display("FAIL request_timeout: pending=%b required 0000", req_valid);
      req_valid = 4'b0000;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_rsp.size() != 0 || busy) && n < 40000) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_rsp.size() != 0 || busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: outstanding=%0d required 0", exp_rsp.size());
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [26:0] got, want;
    got  = {mdio_mdc, mdio_t, mdio_o, req_ready, rsp_valid, rsp_rdata, rsp_err, busy};
    want = {1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: outputs=%h required %h", tag, got, want);
    end
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    check_reset_outputs("reset_values");
    bd_aresetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_write_p0();
    phy_present = 1'b0;
    set_port(0, 1'b1, 5'd1, 5'd0, 16'h1140);
    request(4'b0001);
    wait_idle();
    checks++;
    if (last_line !== 64'hFFFF_FFFF_5082_1140) begin
      errors++;
      $display("FAIL write_p0_stream: line=%h required %h", last_line, 64'hFFFF_FFFF_5082_1140);
    end
    $display("write port0 phy=1 reg=0 data=1140 done");
  endtask

  task automatic test_read_p2();
    phy_present = 1'b1;
    phy_data = 16'h0141;
    set_port(2, 1'b0, 5'd3, 5'd2, 16'h0000);
    request(4'b0100);
    wait_idle();
    $display("read port2 phy=3 reg=2 done");
  endtask

  task automatic test_no_phy();
    phy_present = 1'b0;
    set_port(3, 1'b0, 5'd7, 5'd31, 16'h0000);
    request(4'b1000);
    wait_idle();
    $display("read port3 no phy done");
  endtask

  task automatic test_round_robin();
    int n = 0;
    int want[5] = '{0, 1, 2, 3, 0};
    phy_present = 1'b0;
    bd_aresetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    grant_log.delete();
    for (int p = 0; p < 4; p++) set_port(p, 1'b1, 5'(p + 8), 5'(p), 16'(16'hA000 + p));
    req_valid = 4'b1111;
    bd_aresetn = 1'b1;
    while (grant_log.size() < 5 && n < 30000) begin
      @(negedge clk); #1;
      n++;
    end
    req_valid = 4'b0000;
    wait_idle();
    checks++;
    if (grant_log.size() != 5) begin
      errors++;
      $display("FAIL rr_grant_count: %0d grants required 5", grant_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (grant_log[i] !== want[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: port %0d required %0d", i, grant_log[i], want[i]);
        end
      end
    end
    $display("round robin grants observed=%0d", grant_log.size());
  endtask

  task automatic test_mid_reset();
    int n = 0;
    int f0;
    phy_present = 1'b0;
    set_port(1, 1'b1, 5'd4, 5'd9, 16'h5A5A);
    req_valid = 4'b0010;
    while (!(in_frame && idx == 40) && n < 10000) begin
      @(negedge clk); #1;
      req_valid = req_valid & ~req_ready;
      n++;
    end
    checks++;
    if (!(in_frame && idx == 40)) begin
      errors++;
      $display("FAIL mid_reset_reach: bit=%0d required 40", idx);
    end
    req_valid = 4'b0000;
    bd_aresetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset_values");
    repeat (3) @(negedge clk);
    #1;
    bd_aresetn = 1'b1;
    grant_log.delete();
    f0 = frames_done;
    set_port(0, 1'b1, 5'd2, 5'd4, 16'hA5A5);
    set_port(1, 1'b1, 5'd6, 5'd5, 16'h3C3C);
    request(4'b0011);
    wait_idle();
    checks++;
    if (grant_log.size() == 0 || grant_log[0] !== 0 || frames_done - f0 !== 2) begin
      errors++;
      $display("FAIL mid_reset_recover: first=%0d frames=%0d required first=0 frames=2",
               (grant_log.size() == 0) ? -1 : grant_log[0], frames_done - f0);
    end
    $display("mid-frame reset recovered frames=%0d", frames_done - f0);
  endtask

  task automatic test_mdc_div2();
    int n = 0, len = 0, highs = 0, last_rise = -1, bad = 0;
    logic prev;
    req_write_f = 4'b0000;
    req_phyad_f[4:0] = 5'd5;
    req_regad_f[4:0] = 5'd1;
    req_valid_f = 4'b0001;
    while (!req_ready_f[0] && n < 100) begin @(negedge clk); n++; end
    req_valid_f = 4'b0000;
    n = 0;
    while (mdio_t_f && n < 100) begin @(negedge clk); n++; end
    while (rsp_valid_f == 4'b0000 && len < 1000) begin @(negedge clk); len++; end
    checks++;
    if (len !== 256) begin
      errors++;
      $display("FAIL div2_frame_len: %0d clocks required 256", len);
    end
    checks++;
    if ({rsp_valid_f, rsp_rdata_f, rsp_err_f} !== {4'b0001, 16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL div2_rsp: valid=%b rdata=%h err=%b required 0001 ffff 1", rsp_valid_f, rsp_rdata_f, rsp_err_f);
    end
    prev = mdio_mdc_f;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (mdio_mdc_f) highs++;
      if (mdio_mdc_f && !prev) begin
        if (last_rise >= 0 && i - last_rise != 4) bad++;
        last_rise = i;
      end
      prev = mdio_mdc_f;
    end
    checks++;
    if (highs !== 8 || bad !== 0 || last_rise < 0) begin
      errors++;
      $display("FAIL div2_mdc: high=%0d of 16 bad_periods=%0d required 8 and 0", highs, bad);
    end
    $display("mdc_div2 read len=%0d high=%0d", len, highs);
  endtask

  initial begin
    test_reset();
    test_write_p0();
    test_read_p2();
    test_no_phy();
    test_round_robin();
    test_mid_reset();
    test_mdc_div2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sgmii_mdio_sched.md
# sgmii_mdio_sched

Shared MDIO management controller for the four SGMII PHY ports. It arbitrates round-robin among four per-port register-access requesters and serialises each granted request into an IEEE 802.3 Clause 22 frame on the single board MDC/MDIO pair. It generates MDC from the PL clock and returns read data and a no-PHY error per transaction. It sits in the PL between the per-port management logic and the top-level `mdio_mdc`/`mdio_mdio` pins, with the IOBUF kept outside this block.

## Interface
- `MDC_DIV`, default 25: system clocks per MDC half-period; 125 MHz / (2·25) = 2.5 MHz. Legal range ≥2.
- Requester count is fixed at 4 and is not a parameter.

Ports:
- `bd_fclk0_125m`  in  1  system clock, 125 MHz
- `bd_aresetn`  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- `req_valid`  in  4  per-port request pending; held until `req_ready` for that port
- `req_write`  in  4  per-port 1 = write, 0 = read
- `req_phyad`  in  20  per-port PHY address; port i occupies bits [5i+4:5i]
- `req_regad`  in  20  per-port register address, same packing as `req_phyad`
- `req_wdata`  in  64  per-port write data; port i occupies bits [16i+15:16i]
- `req_ready`  out  4  one-cycle accept pulse, one-hot
- `rsp_valid`  out  4  one-cycle completion pulse, one-hot, for the port that was granted
- `rsp_rdata`  out  16  read data, valid with `rsp_valid`, held until the next `rsp_valid`
- `rsp_err`  out  1  read turnaround bit was sampled high (no PHY responded); valid with `rsp_valid`
- `busy`  out  1  high from grant until the `rsp_valid` cycle, inclusive
- `mdio_mdc`  out  1  management clock
- `mdio_o`  out  1  MDIO output data
- `mdio_t`  out  1  MDIO tristate control: 1 = release (hi-Z), 0 = drive
- `mdio_i`  in  1  MDIO input data

## Operation
- MDC generator:
  - A free-running counter counts 0..MDC_DIV-1. `mdio_mdc` toggles when the counter wraps.
  - A wrap with MDC=1 produces the *fall tick*. A wrap with MDC=0 produces the *rise tick*.
  - MDC runs continuously, including when idle.
- Frame format (64 bits, MSB first): 32×`1` preamble, ST=`01`, OP (`01` write / `10` read), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0].
  - Write TA is `10`.
  - Read TA is Z, then PHY-driven `0`.
- FSM states: IDLE, WAIT_EDGE, SHIFT, DONE.
  - **IDLE**: if any `req_valid` is set, grant the first set bit searching upward from `last+1` mod 4. In the same cycle, pulse `req_ready[g]`, capture the fields into a 64-bit shift register, set `busy`, and go to WAIT_EDGE.
  - **WAIT_EDGE**: on the next fall tick, drive bit 0 (`mdio_t`=0, `mdio_o`=bit) and go to SHIFT. The bit counter starts at 0.
  - **SHIFT**: on each fall tick, advance to the next bit. On the fall tick after bit 63 has been presented, set `mdio_t`=1 and `mdio_o`=1 and go to DONE.
  - **DONE**: for one cycle, pulse `rsp_valid[g]`, update `rsp_rdata`/`rsp_err`, set `last`=g, clear `busy`, and go to IDLE.
- Read direction:
  - `mdio_t`=1 from the fall tick that presents bit 46 (first TA bit) through the end of the frame.
  - On the rise tick of bit 47, sample `mdio_i` into the error flag (1 = error).
  - On the rise ticks of bits 48..63, shift `mdio_i` into the data register, MSB first.
- Write transactions: `rsp_rdata`=0 and `rsp_err`=0.
- `req_*` inputs are ignored except in the IDLE grant cycle. Changes to a request after it is accepted have no effect.

## Timing
- Reset values: `mdio_mdc`=0, `mdio_t`=1, `mdio_o`=1, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0. MDC counter=0, `last`=3 (port 0 wins the first arbitration).
- Asserting reset mid-frame aborts the frame immediately: MDIO is released and no `rsp_valid` is produced for the aborted request.
- Frame duration: 64 MDC periods (128·MDC_DIV clocks), measured from the fall tick that starts bit 0 to the fall tick that ends bit 63.
- Grant-to-first-bit latency: 1 to 2·MDC_DIV clocks, depending on MDC phase.
- `rsp_valid` asserts in the clock after the final fall tick.
- Back-to-back transactions: at least one idle MDC period (MDIO hi-Z) between frames.
- Simultaneous requests are serviced round-robin. A port re-requesting immediately cannot starve the others.
- Output changes occur only on fall ticks. Input sampling occurs only on rise ticks.

## Test plan
- **Write, port 0**: PHYAD=1, REGAD=0, data 0x1140 → bench must:
  - decode the MDIO pin stream as 32 ones, then `0101 00001 00000 10 0001000101000000`;
  - see `rsp_valid`=0001, `rsp_err`=0, and a frame length of 3200 clocks.
- **Read, port 2**: PHY model drives 0x0141 after TA=0 → `rsp_valid`=0100, `rsp_rdata`=0x0141, `rsp_err`=0, and `mdio_t`=1 from bit 46 onward.
- **Read with no PHY** (pull-up only) → `rsp_err`=1 and `rsp_rdata`=0xFFFF.
- **All four ports requesting continuously from reset**:
  - grant order must be 0,1,2,3,0;
  - exactly one `req_ready` per grant;
  - `busy` stays high across each frame.
- **Mid-frame reset**: assert `bd_aresetn`=0 at bit 40 → all outputs take their reset values immediately. After release, port 0 is served first and its frame is complete.
- **MDC_DIV=2**: a read frame takes 256 clocks, with an MDC period of 4 clocks and a 50% duty cycle.
